// File: rtl/prescale_ctrl.sv
// prescale_ctrl: per-channel prescaled count-enable pulse generator with a shared debug halt.
// Configuration is shadowed so that live changes restart the division cleanly.
module prescale_ctrl #(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       timer_en,
   input  logic [NUM_CH-1:0]       div_en,
   input  logic [NUM_CH-1:0]       div_mode,
   input  logic [NUM_CH*DIV_W-1:0] div_val,
   input  logic                    dbg_mode,
   input  logic                    halt_req,
   output logic                    halt_ack,
   output logic [NUM_CH-1:0]       cnt_en
);
   localparam int PRE_W = 2**DIV_W - 1;
   logic halt_en;
   logic halt_ack_d;
   logic halt_ack_q;
   assign halt_en = dbg_mode & halt_req;
   always_comb halt_ack_d = halt_en;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) halt_ack_q <= 1'b0;
      else        halt_ack_q <= halt_ack_d;
   end
   assign halt_ack = halt_ack_q;
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [DIV_W-1:0] val;
      logic [DIV_W-1:0] val_d;
      logic [DIV_W-1:0] val_q;
      logic             en_d;
      logic             en_q;
      logic             mode_d;
      logic             mode_q;
      logic [PRE_W-1:0] therm;
      logic [PRE_W-1:0] limit;
      logic [PRE_W-1:0] cnt_d;
      logic [PRE_W-1:0] cnt_q;
      logic             cfg_chg;
      logic             at_lim;
      assign val = div_val[g*DIV_W +: DIV_W];
      // a thermometer of val ones is (1 << val) - 1 without a wide shifter
      always_comb begin
         therm = '0;
         for (int j = 0; j < PRE_W; j++) therm[j] = j < int'(val);
         limit   = div_mode[g] ? PRE_W'(val) : therm;
         cfg_chg = {div_en[g], div_mode[g], val} != {en_q, mode_q, val_q};
         at_lim  = cnt_q == limit;
         en_d    = halt_en ? en_q   : div_en[g];
         mode_d  = halt_en ? mode_q : div_mode[g];
         val_d   = halt_en ? val_q  : val;
         cnt_d   = halt_en ? cnt_q :
                   (!timer_en[g] || !div_en[g] || cfg_chg || at_lim) ? '0 : cnt_q + 1'b1;
      end
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            en_q   <= 1'b0;
            mode_q <= 1'b0;
            val_q  <= '0;
            cnt_q  <= '0;
         end else begin
            en_q   <= en_d;
            mode_q <= mode_d;
            val_q  <= val_d;
            cnt_q  <= cnt_d;
         end
      end
      assign cnt_en[g] = timer_en[g] & ~halt_en & ~cfg_chg & (~div_en[g] | (limit == '0) | at_lim);
   end
endmodule

// File: tb/tb_prescale_ctrl.sv
// tb_prescale_ctrl: randomized checks of prescale_ctrl against a period-based reference model.
module tb_prescale_ctrl;
   localparam int NUM_CH = 4;
   localparam int DIV_W  = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NUM_CH-1:0] timer_en = '0;
   logic [NUM_CH-1:0] div_en = '0;
   logic [NUM_CH-1:0] div_mode = '0;
   logic [NUM_CH*DIV_W-1:0] div_val = '0;
   logic dbg_mode = 1'b0;
   logic halt_req = 1'b0;
   logic halt_ack;
   logic [NUM_CH-1:0] cnt_en;
   int total = 0;
   int bad = 0;
   int phase[NUM_CH];
   bit sh_en[NUM_CH];
   bit sh_mode[NUM_CH];
   int sh_val[NUM_CH];
   bit m_ack;

   prescale_ctrl #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
      .clk(clk), .rst_n(rst_n), .timer_en(timer_en), .div_en(div_en), .div_mode(div_mode),
      .div_val(div_val), .dbg_mode(dbg_mode), .halt_req(halt_req), .halt_ack(halt_ack),
      .cnt_en(cnt_en)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // Model: each channel is a position within a period of 2**v, v+1 or 1 cycles.
   function automatic int vget(int c);
      return int'(div_val[c*DIV_W +: DIV_W]);
   endfunction
   function automatic bit changed(int c);
      return div_en[c] != sh_en[c] || div_mode[c] != sh_mode[c] || vget(c) != sh_val[c];
   endfunction
   function automatic int period(int c);
      return !div_en[c] ? 1 : div_mode[c] ? vget(c) + 1 : (1 << vget(c));
   endfunction
   function automatic logic [NUM_CH-1:0] model_en();
      logic [NUM_CH-1:0] r;
      bit halt;
      halt = dbg_mode & halt_req;
      r = '0;
      for (int c = 0; c < NUM_CH; c++)
         r[c] = timer_en[c] & !halt & !changed(c) & (phase[c] == period(c) - 1);
      return r;
   endfunction
   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         phase[c] = 0; sh_en[c] = 0; sh_mode[c] = 0; sh_val[c] = 0;
      end
      m_ack = 0;
   endtask
   task automatic model_edge();
      bit halt;
      bit chg;
      int p;
      halt = dbg_mode & halt_req;
      if (!halt) begin
         for (int c = 0; c < NUM_CH; c++) begin
            chg = changed(c);
            p = period(c);
            phase[c] = (!timer_en[c] || !div_en[c] || chg || phase[c] == p - 1) ? 0 : phase[c] + 1;
            sh_en[c] = div_en[c]; sh_mode[c] = div_mode[c]; sh_val[c] = vget(c);
         end
      end
      m_ack = halt;
   endtask
   task automatic clk_cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask
   task automatic set_ch(int c, bit te, bit den, bit mode, int v);
      timer_en[c] = te;
      div_en[c] = den;
      div_mode[c] = mode;
      div_val[c*DIV_W +: DIV_W] = DIV_W'(v);
   endtask

   task automatic test_reset();
      #12;
      total++; if (halt_ack !== 1'b0) begin bad++; $display("FAIL reset_ack act=%b req=0", halt_ack); end
      total++; if (cnt_en !== '0) begin bad++; $display("FAIL reset_en act=%b req=0", cnt_en); end
      dbg_mode = 1; halt_req = 1;
      @(posedge clk); #1;
      total++; if (halt_ack !== 1'b0) begin bad++; $display("FAIL reset_hold_ack act=%b req=0", halt_ack); end
      dbg_mode = 0; halt_req = 0;
      @(posedge clk); #1;
      rst_n = 1;
      model_reset();
   endtask

   task automatic test_basic();
      logic [NUM_CH-1:0] exp;
      int n0 = 0, n1 = 0, n2 = 0;
      set_ch(0, 1, 1, 0, 3);
      set_ch(1, 1, 1, 1, 4);
      set_ch(2, 1, 0, 0, $urandom_range(0, 15));
      set_ch(3, 1, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 4));
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         exp = model_en();
         total++; if (cnt_en !== exp) begin bad++; $display("FAIL basic_en cyc=%0d act=%b req=%b", i, cnt_en, exp); end
         if (i == 0) begin
            total++; if (cnt_en[0] !== 1'b0) begin bad++; $display("FAIL basic_first act=%b req=0", cnt_en[0]); end
         end
         if (i >= 2 && i < 34) n0 += int'(cnt_en[0]);
         if (i >= 2 && i < 32) begin n1 += int'(cnt_en[1]); n2 += int'(cnt_en[2]); end
         clk_cycle();
      end
      total++; if (n0 != 4) begin bad++; $display("FAIL basic_ch0_count act=%0d req=4", n0); end
      total++; if (n1 != 6) begin bad++; $display("FAIL basic_ch1_count act=%0d req=6", n1); end
      total++; if (n2 != 30) begin bad++; $display("FAIL basic_ch2_count act=%0d req=30", n2); end
   endtask

   task automatic test_halt();
      logic [NUM_CH-1:0] exp;
      int first = -1;
      for (int i = 0; i < 20; i++) begin
         if (phase[0] == 5) break;
         @(negedge clk);
         exp = model_en();
         total++; if (cnt_en !== exp) begin bad++; $display("FAIL halt_pre_en act=%b req=%b", cnt_en, exp); end
         clk_cycle();
      end
      total++; if (phase[0] != 5) begin bad++; $display("FAIL halt_reach_cnt5 act=%0d req=5", phase[0]); end
      dbg_mode = 1; halt_req = 1;
      set_ch(1, 1, 1, 0, $urandom_range(0, 3));
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         total++; if (cnt_en !== '0) begin bad++; $display("FAIL halt_en k=%0d act=%b req=0", k, cnt_en); end
         total++; if (halt_ack !== (k >= 1)) begin bad++; $display("FAIL halt_ack k=%0d act=%b req=%b", k, halt_ack, k >= 1); end
         clk_cycle();
      end
      halt_req = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         exp = model_en();
         total++; if (cnt_en !== exp) begin bad++; $display("FAIL halt_post_en k=%0d act=%b req=%b", k, cnt_en, exp); end
         if (k < 2) begin
            total++; if (halt_ack !== (k == 0)) begin bad++; $display("FAIL halt_rel_ack k=%0d act=%b req=%b", k, halt_ack, k == 0); end
         end
         if (cnt_en[0] && first < 0) first = k;
         clk_cycle();
      end
      total++; if (first != 2) begin bad++; $display("FAIL halt_resume_idx act=%0d req=2", first); end
   endtask

   task automatic test_cfg_change();
      logic [NUM_CH-1:0] exp;
      set_ch(0, 1, 1, 0, 3);
      for (int i = 0; i < 20; i++) begin
         if (phase[0] == 5) break;
         @(negedge clk);
         exp = model_en();
         total++; if (cnt_en !== exp) begin bad++; $display("FAIL cfg_pre_en act=%b req=%b", cnt_en, exp); end
         clk_cycle();
      end
      set_ch(0, 1, 1, 0, 1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         exp = model_en();
         total++; if (cnt_en !== exp) begin bad++; $display("FAIL cfg_en k=%0d act=%b req=%b", k, cnt_en, exp); end
         total++; if (cnt_en[0] !== (k > 0 && k % 2 == 0)) begin bad++; $display("FAIL cfg_ch0 k=%0d act=%b req=%b", k, cnt_en[0], k > 0 && k % 2 == 0); end
         clk_cycle();
      end
   endtask

   task automatic test_reset_mid();
      logic [NUM_CH-1:0] exp;
      int first = -1;
      set_ch(0, 1, 1, 0, 3);
      for (int i = 0; i < 20; i++) begin
         if (phase[0] == 6) break;
         @(negedge clk);
         exp = model_en();
         total++; if (cnt_en !== exp) begin bad++; $display("FAIL rst_pre_en act=%b req=%b", cnt_en, exp); end
         clk_cycle();
      end
      dbg_mode = 1; halt_req = 1;
      clk_cycle();
      total++; if (halt_ack !== 1'b1) begin bad++; $display("FAIL rst_pre_ack act=%b req=1", halt_ack); end
      halt_req = 0;
      rst_n = 0;
      model_reset();
      #1;
      total++; if (halt_ack !== 1'b0) begin bad++; $display("FAIL rst_async_ack act=%b req=0", halt_ack); end
      exp = model_en();
      total++; if (cnt_en !== exp) begin bad++; $display("FAIL rst_in_en act=%b req=%b", cnt_en, exp); end
      @(posedge clk); #1;
      rst_n = 1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         exp = model_en();
         total++; if (cnt_en !== exp) begin bad++; $display("FAIL rst_post_en k=%0d act=%b req=%b", k, cnt_en, exp); end
         if (cnt_en[0] && first < 0) first = k;
         clk_cycle();
      end
      total++; if (first != 8) begin bad++; $display("FAIL rst_first_pulse act=%0d req=8", first); end
   endtask

   task automatic test_random();
      logic [NUM_CH-1:0] exp;
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if ($urandom_range(0, 15) == 0)
               set_ch(c, timer_en[c], 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) timer_en[c] = ~timer_en[c];
         end
         if ($urandom_range(0, 7) == 0) halt_req = ~halt_req;
         dbg_mode = 1'($urandom_range(0, 3) != 0);
         @(negedge clk);
         exp = model_en();
         total++; if (cnt_en !== exp) begin bad++; $display("FAIL rand_en cyc=%0d act=%b req=%b", i, cnt_en, exp); end
         total++; if (halt_ack !== m_ack) begin bad++; $display("FAIL rand_ack cyc=%0d act=%b req=%b", i, halt_ack, m_ack); end
         clk_cycle();
      end
      dbg_mode = 0; halt_req = 0;
   endtask

   task automatic test_long();
      logic [NUM_CH-1:0] exp;
      int f1 = -1, f2 = -1;
      set_ch(0, 1, 1, 0, 15);
      for (int i = 0; i < 70000; i++) begin
         @(negedge clk);
         exp = model_en();
         total++; if (cnt_en !== exp) begin bad++; $display("FAIL long_en cyc=%0d act=%b req=%b", i, cnt_en, exp); end
         if (cnt_en[0]) begin
            if (f1 < 0) f1 = i;
            else f2 = i;
         end
         clk_cycle();
         if (f2 >= 0) break;
      end
      total++; if (f1 != 32768) begin bad++; $display("FAIL long_first act=%0d req=32768", f1); end
      total++; if (f2 - f1 != 32768) begin bad++; $display("FAIL long_period act=%0d req=32768", f2 - f1); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_halt();
      test_cfg_change();
      test_reset_mid();
      test_random();
      test_long();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
